// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-FF synchronizer, optional glitch filter (QDEC_FILTER_EN),
// Gray-sequence decode into step/updn strobes, wrapping position and sticky err.
module quad_decoder #(
    parameter int CNT_W    = 10,
    parameter int FILT_LEN = 4
) (
    input  logic             clk5m,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic             step,
    output logic             updn,
    output logic [CNT_W-1:0] pos,
    output logic             err,
    output logic [1:0]       phase
);

    typedef enum logic {INIT, TRACK} state_t;

    logic [1:0] a_sync, b_sync;
    logic [1:0] raw, cur;
    state_t     state, state_nxt;
    logic [4:0] init_cnt;
    logic       init_done, load, track;
    logic [1:0] delta;
    logic       fwd, rev, dbl;

    always_ff @(posedge clk5m) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[0], enc_a};
            b_sync <= {b_sync[0], enc_b};
        end
    end

    assign raw = {a_sync[1], b_sync[1]};

`ifdef QDEC_FILTER_EN
    localparam int INIT_WAIT = 2 + FILT_LEN;

    logic [1:0]      filt;
    logic [1:0][3:0] fcnt;

    // A channel flips only after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk5m) begin
        if (rst) begin
            filt <= '0;
            fcnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] != filt[i]) begin
                    if (fcnt[i] == 4'(FILT_LEN - 1)) begin
                        filt[i] <= raw[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 4'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    assign cur = filt;
`else
    localparam int INIT_WAIT = 2;

    assign cur = raw;
`endif

    filt_len_range: assert property (@(posedge clk5m) (FILT_LEN >= 2) && (FILT_LEN <= 15));

    assign init_done = (init_cnt == 5'(INIT_WAIT));

    always_ff @(posedge clk5m) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT && !init_done)
                init_cnt <= init_cnt + 5'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_done) state_nxt = TRACK;
            TRACK:   state_nxt = TRACK;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        track = 1'b0;
        case (state)
            INIT:    load  = init_done;
            TRACK:   track = 1'b1;
            default: ;
        endcase
    end

    // Map Gray code to sequence index so a phase move is a mod-4 difference.
    function automatic logic [1:0] gray_idx(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    assign delta = gray_idx(cur) - gray_idx(phase);
    assign fwd   = track && (delta == 2'd1);
    assign rev   = track && (delta == 2'd3);
    assign dbl   = track && (delta == 2'd2);

    always_ff @(posedge clk5m) begin
        if (rst) begin
            step  <= 1'b0;
            updn  <= 1'b0;
            pos   <= '0;
            err   <= 1'b0;
            phase <= 2'b00;
        end else begin
            step <= 1'b0;
            if (load || track)
                phase <= cur;
            if (clr) begin
                pos <= '0;
                err <= 1'b0;
            end else if (en) begin
                if (fwd) begin
                    step <= 1'b1;
                    updn <= 1'b0;
                    pos  <= pos + CNT_W'(1);
                end else if (rev) begin
                    step <= 1'b1;
                    updn <= 1'b1;
                    pos  <= pos - CNT_W'(1);
                end else if (dbl) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized bench for quad_decoder against a transition-level reference model.
module tb_quad_decoder;

    localparam int CNT_W    = 10;
    localparam int FILT_LEN = 4;
    localparam int MODV     = 1 << CNT_W;
`ifdef QDEC_FILTER_EN
    localparam int LAT = 2 + FILT_LEN;
`else
    localparam int LAT = 2;
`endif

    logic             clk5m = 1'b0;
    logic             rst, en, clr, enc_a, enc_b;
    logic             step, updn, err;
    logic [CNT_W-1:0] pos;
    logic [1:0]       phase;

    quad_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
        .clk5m(clk5m), .rst(rst), .en(en), .clr(clr),
        .enc_a(enc_a), .enc_b(enc_b),
        .step(step), .updn(updn), .pos(pos), .err(err), .phase(phase)
    );

    always #5 clk5m = ~clk5m;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;

    always @(negedge clk5m) if (step) step_cnt++;

    logic [1:0] gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    int         m_pos, m_steps;
    bit         m_err, m_updn;
    logic [1:0] m_ph;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk5m);
        #1;
    endtask

    function automatic int gpos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] p, input bit back);
        return gray_seq[(gpos(p) + (back ? 3 : 1)) % 4];
    endfunction

    task automatic model_move(input logic [1:0] nx, input bit enb, input bit clrd);
        int d;
        d = (gpos(nx) - gpos(m_ph) + 4) % 4;
        if (clrd) begin
            m_pos = 0;
            m_err = 0;
        end else if (enb) begin
            if (d == 1) begin
                m_pos = (m_pos + 1) % MODV; m_updn = 0; m_steps++;
            end else if (d == 3) begin
                m_pos = (m_pos + MODV - 1) % MODV; m_updn = 1; m_steps++;
            end else if (d == 2) begin
                m_err = 1;
            end
        end
        m_ph = nx;
    endtask

    task automatic model_reset(input logic [1:0] ab);
        m_pos = 0; m_err = 0; m_updn = 0; m_ph = ab;
    endtask

    task automatic drive(input logic [1:0] ab);
        enc_a = ab[1];
        enc_b = ab[0];
    endtask

    task automatic move(input logic [1:0] nx);
        drive(nx);
        model_move(nx, en, 1'b0);
        tick(LAT + 4);
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_pos = 0;
        m_err = 0;
        tick(1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pos"},   int'(pos),   m_pos);
        chk({tag, ".err"},   int'(err),   int'(m_err));
        chk({tag, ".updn"},  int'(updn),  int'(m_updn));
        chk({tag, ".phase"}, int'(phase), int'(m_ph));
        chk({tag, ".steps"}, step_cnt,    m_steps);
    endtask

    initial begin
        int s0, r;
        logic [1:0] c, g;
        m_steps = 0;
        rst = 1'b1; en = 1'b1; clr = 1'b0;
        drive(2'b00);
        tick(3);
        chk("rst.pos",   int'(pos),   0);
        chk("rst.step",  int'(step),  0);
        chk("rst.err",   int'(err),   0);
        chk("rst.updn",  int'(updn),  0);
        chk("rst.phase", int'(phase), 0);
        rst = 1'b0;
        model_reset(2'b00);
        tick(LAT + 6);

        // forward run, first transition checked cycle-exact
        drive(2'b01);
        model_move(2'b01, 1'b1, 1'b0);
        tick(LAT);
        chk("lat.pre", int'(step), 0);
        tick(1);
        chk("lat.hit", int'(step), 1);
        tick(1);
        chk("lat.post", int'(step), 0);
        tick(6);
        for (int i = 1; i < 16; i++) move(nxt(m_ph, 1'b0));
        chk("fwd.pos16", int'(pos), 16);
        check_all("fwd");

        // reverse wrap
        clr_pulse();
        move(2'b10);
        chk("wrap.pos", int'(pos), MODV - 1);
        check_all("wrap1");
        move(2'b00);
        check_all("wrap2");

        // illegal jump at pos 5, then clr colliding with a valid step
        move(2'b10);
        clr_pulse();
        for (int i = 0; i < 5; i++) move(nxt(m_ph, 1'b0));
        chk("ill.pre", int'(pos), 5);
        s0 = step_cnt;
        move(2'b11);
        chk("ill.err", int'(err), 1);
        chk("ill.nostep", step_cnt - s0, 0);
        check_all("ill");
        drive(2'b10);
        s0 = step_cnt;
        tick(LAT);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        model_move(2'b10, 1'b1, 1'b1);
        tick(4);
        chk("clrstep.nostep", step_cnt - s0, 0);
        check_all("clrstep");

        // reset while inputs sit at 11
        drive(2'b11);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset(2'b11);
        tick(LAT + 6);
        check_all("rst11");
        move(2'b10);
        chk("rst11.pos1", int'(pos), 1);

        // enable gating
        en = 1'b0;
        for (int i = 0; i < 3; i++) move(nxt(m_ph, 1'b0));
        en = 1'b1;
        tick(4);
        check_all("en_off");
        move(nxt(m_ph, 1'b0));
        check_all("en_on");

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) clr_pulse();
            else if (r < 3) move(gray_seq[(gpos(m_ph) + 2) % 4]);
            else if (r == 3) en = ~en;
            else move(nxt(m_ph, $urandom_range(0, 1) == 1));
            check_all("rnd");
        end
        en = 1'b1;
        tick(2);

        // 2-clock glitch on A
        c = m_ph;
        g = c ^ 2'b10;
        s0 = step_cnt;
`ifdef QDEC_FILTER_EN
        drive(g);
        tick(2);
        drive(c);
        tick(LAT + 4);
        chk("glitch.nostep", step_cnt - s0, 0);
        check_all("glitch");
        drive(nxt(m_ph, 1'b0));
        model_move(nxt(m_ph, 1'b0), 1'b1, 1'b0);
        tick(LAT);
        chk("flat.pre", int'(step), 0);
        tick(1);
        chk("flat.hit", int'(step), 1);
        tick(4);
        check_all("flat");
`else
        drive(g);
        model_move(g, 1'b1, 1'b0);
        tick(2);
        drive(c);
        model_move(c, 1'b1, 1'b0);
        tick(LAT + 4);
        chk("glitch.twostep", step_cnt - s0, 2);
        check_all("glitch");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
